// File: rtl/score_disp_pkg.sv
// Shared constants, glyph table, FSM state type and threshold helper
// for the LED-matrix decimal score display.
package score_disp_pkg;

    localparam int GLYPH_W = 15;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 15'h0000;

    localparam logic [GLYPH_W-1:0] GLYPH_0 = 15'h7B6F;
    localparam logic [GLYPH_W-1:0] GLYPH_1 = 15'h2C97;
    localparam logic [GLYPH_W-1:0] GLYPH_2 = 15'h73E7;
    localparam logic [GLYPH_W-1:0] GLYPH_3 = 15'h73CF;
    localparam logic [GLYPH_W-1:0] GLYPH_4 = 15'h5BC9;
    localparam logic [GLYPH_W-1:0] GLYPH_5 = 15'h79CF;
    localparam logic [GLYPH_W-1:0] GLYPH_6 = 15'h79EF;
    localparam logic [GLYPH_W-1:0] GLYPH_7 = 15'h7249;
    localparam logic [GLYPH_W-1:0] GLYPH_8 = 15'h7BEF;
    localparam logic [GLYPH_W-1:0] GLYPH_9 = 15'h7BCF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Elaboration-time 10**n; 64 bits so the threshold never wraps for sane digit counts
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_glyph.sv
// Combinational BCD digit to 3x5 glyph lookup; bit 14 is the top-left pixel.
module digit_glyph
    import score_disp_pkg::*;
(
    input  logic [3:0]         bcd,
    output logic [GLYPH_W-1:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        case (bcd)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/score_digits_seq.sv
// Sequential binary-to-BCD formatter (double dabble, one bit per clock) with
// saturation, optional leading-zero blanking and per-digit glyph outputs.
module score_digits_seq
    import score_disp_pkg::*;
#(
    parameter int BIN_W      = 12,
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    input  logic                          blank_lz,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [4*NUM_DIGITS-1:0]       bcd,
    output logic [GLYPH_W*NUM_DIGITS-1:0] glyphs
);

    localparam int ACC_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CMP_W = (BIN_W > 64) ? BIN_W : 64;
    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] all_nines();
        logic [ACC_W-1:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'h9;
        end
        return r;
    endfunction

    localparam logic [ACC_W-1:0] NINES = all_nines();

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] shreg;
    logic [ACC_W-1:0] acc;
    logic             ovf_q;
    logic             blank_q;

    logic [CMP_W-1:0]                bin_ext;
    logic [ACC_W-1:0]                sat_val;
    logic [NUM_DIGITS-1:0]           blank_mask;
    logic                            lead;
    logic [GLYPH_W*NUM_DIGITS-1:0]   raw_glyphs;
    logic [GLYPH_W*NUM_DIGITS-1:0]   glyph_out;

    assign bin_ext = CMP_W'(bin_in);
    assign sat_val = ovf_q ? NINES : acc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            glyphs   <= {NUM_DIGITS{GLYPH_BLANK}};
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) cnt <= CNT_W'(BIN_W);
                end
                SHIFT: begin
                    busy <= 1'b1;
                    cnt  <= cnt - 1'b1;
                end
                FINISH: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    overflow <= ovf_q;
                    bcd      <= sat_val;
                    glyphs   <= glyph_out;
                end
                default: ;
            endcase
        end
    end

    // Datapath carries no reset: it is always reloaded before it is observed
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            shreg   <= bin_in;
            acc     <= '0;
            ovf_q   <= (bin_ext >= CMP_W'(OVF_LIMIT));
            blank_q <= blank_lz;
        end else if (state == SHIFT) begin
            {acc, shreg} <= {add3(acc), shreg} << 1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        digit_glyph u_glyph (
            .bcd   (sat_val[4*g +: 4]),
            .glyph (raw_glyphs[GLYPH_W*g +: GLYPH_W])
        );
    end

    // A digit is blanked only if it and every digit above it are zero; digit 0 always shows
    always_comb begin
        lead       = blank_q;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead          = lead & (sat_val[4*i +: 4] == 4'd0);
            blank_mask[i] = lead;
        end
    end

    always_comb begin
        glyph_out = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            glyph_out[GLYPH_W*i +: GLYPH_W] =
                blank_mask[i] ? GLYPH_BLANK : raw_glyphs[GLYPH_W*i +: GLYPH_W];
        end
    end

endmodule

// File: tb/tb_score_digits_seq.sv
// Directed-vector bench for score_digits_seq: default instance plus a 3-digit instance.
module tb_score_digits_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic [11:0] bin_in = '0;
    logic        blank_lz = 1'b0;

    logic        busy, done, overflow;
    logic [15:0] bcd;
    logic [59:0] glyphs;
    logic        busy3, done3, overflow3;
    logic [11:0] bcd3;
    logic [44:0] glyphs3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    score_digits_seq #(.BIN_W(12), .NUM_DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .blank_lz(blank_lz),
        .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .glyphs(glyphs)
    );

    score_digits_seq #(.BIN_W(12), .NUM_DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bin_in(bin_in), .blank_lz(blank_lz),
        .busy(busy3), .done(done3), .overflow(overflow3), .bcd(bcd3), .glyphs(glyphs3)
    );

    typedef struct {
        logic [11:0] bin;
        logic        blz;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        logic [59:0] exp_glyphs;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] glyph_ref(input int d);
        case (d)
            0: return 15'h7B6F;
            1: return 15'h2C97;
            2: return 15'h73E7;
            3: return 15'h73CF;
            4: return 15'h5BC9;
            5: return 15'h79CF;
            6: return 15'h79EF;
            7: return 15'h7249;
            8: return 15'h7BEF;
            9: return 15'h7BCF;
            default: return 15'h0000;
        endcase
    endfunction

    function automatic logic [15:0] bcd_ref(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [59:0] glyphs_ref(input int v, input logic blz);
        logic [59:0] g;
        int nd, t;
        nd = (v == 0) ? 1 : 0;
        t = v;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        t = v;
        for (int i = 0; i < 4; i++) begin
            g[15*i +: 15] = (blz && i >= nd) ? 15'h0000 : glyph_ref(t % 10);
            t = t / 10;
        end
        return g;
    endfunction

    // Pulse start for one edge, then count edges until done (bounded)
    task automatic convert(input logic [11:0] b, input logic blz, output int lat, output int busy_cnt);
        @(negedge clk);
        bin_in = b; blank_lz = blz; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic convert3(input logic [11:0] b, output int lat);
        @(negedge clk);
        bin_in = b; blank_lz = 1'b1; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 0;
        while (!done3 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, done_seen;

        vecs[0] = '{12'd1234, 1'b0, 16'h1234, 1'b0, {15'h2C97, 15'h73E7, 15'h73CF, 15'h5BC9}};
        vecs[1] = '{12'd42,   1'b1, 16'h0042, 1'b0, {15'h0000, 15'h0000, 15'h5BC9, 15'h73E7}};
        vecs[2] = '{12'd0,    1'b1, 16'h0000, 1'b0, {15'h0000, 15'h0000, 15'h0000, 15'h7B6F}};
        vecs[3] = '{12'd4095, 1'b1, 16'h4095, 1'b0, {15'h5BC9, 15'h7B6F, 15'h7BCF, 15'h79CF}};
        vecs[4] = '{12'd7,    1'b0, 16'h0007, 1'b0, {15'h7B6F, 15'h7B6F, 15'h7B6F, 15'h7249}};
        vecs[5] = '{12'd100,  1'b1, 16'h0100, 1'b0, {15'h0000, 15'h2C97, 15'h7B6F, 15'h7B6F}};
        vecs[6] = '{12'd3008, 1'b1, 16'h3008, 1'b0, {15'h73CF, 15'h7B6F, 15'h7B6F, 15'h7BEF}};
        vecs[7] = '{12'd860,  1'b0, 16'h0860, 1'b0, {15'h7B6F, 15'h7BEF, 15'h79EF, 15'h7B6F}};

        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_glyphs", 64'(glyphs), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            convert(vecs[i].bin, vecs[i].blz, lat, bc);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd13);
            check($sformatf("vec%0d_busycyc", i), 64'(bc), 64'd12);
            check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_bcd", i), 64'(bcd), 64'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_glyphs", i), 64'(glyphs), 64'(vecs[i].exp_glyphs));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_hold", i), 64'(bcd), 64'(vecs[i].exp_bcd));
        end

        // Three-digit instance: saturation then a value just in range
        convert3(12'd4095, lat);
        check("d3_ovf_lat", 64'(lat), 64'd13);
        check("d3_ovf_bcd", 64'(bcd3), 64'h999);
        check("d3_ovf_flag", 64'(overflow3), 64'd1);
        check("d3_ovf_glyphs", 64'(glyphs3), 64'({15'h7BCF, 15'h7BCF, 15'h7BCF}));
        convert3(12'd999, lat);
        check("d3_999_bcd", 64'(bcd3), 64'h999);
        check("d3_999_flag", 64'(overflow3), 64'd0);
        convert3(12'd1000, lat);
        check("d3_1000_flag", 64'(overflow3), 64'd1);
        check("d3_1000_bcd", 64'(bcd3), 64'h999);

        // Start ignored while busy, bin_in changes after capture ignored, back-to-back start
        @(negedge clk);
        bin_in = 12'd1234; blank_lz = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bin_in = 12'd5678 & 12'hFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bin_in = 12'd999;
        lat = 4;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_ign_lat", 64'(lat), 64'd13);
        check("busy_ign_bcd", 64'(bcd), 64'h1234);
        bin_in = 12'd3678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bin_in = 12'd1;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat", 64'(lat), 64'd13);
        check("b2b_bcd", 64'(bcd), 64'h3678);

        // Asynchronous reset mid-conversion
        @(negedge clk);
        bin_in = 12'd4095; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_bcd", 64'(bcd), 64'd0);
        check("arst_glyphs", 64'(glyphs), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("arst_no_done", 64'(done_seen), 64'd0);
        convert(12'd7, 1'b0, lat, bc);
        check("post_rst_lat", 64'(lat), 64'd13);
        check("post_rst_bcd", 64'(bcd), 64'h0007);

        // Full sweep against the decimal and glyph reference
        for (int v = 0; v < 4096; v++) begin
            logic blz;
            blz = (v % 2) == 1;
            convert(12'(v), blz, lat, bc);
            check($sformatf("sweep%0d_lat", v), 64'(lat), 64'd13);
            check($sformatf("sweep%0d_bcd", v), 64'(bcd), 64'(bcd_ref(v)));
            check($sformatf("sweep%0d_glyphs", v), 64'(glyphs), 64'(glyphs_ref(v, blz)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
